mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port 16-bit unified memory between the fetch stage (requester IF) and the
//  mem stage (requester D) of the 16-bit RISC core. It accepts one request at a time, drives the
//  memory port with registered command signals and waits a variable latency for mem_ack.
//  It then returns read data and a one-cycle done pulse to the requester it granted.
//  Sits between the stage-enable controller/datapath and the memory model.
// PARAMETERS
//  AW       16  address width
//  DW       16  data width
//  TIMEOUT  15  max cycles waiting for mem_ack before abort (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1   single clock, all logic on posedge
//  rst        in   1   synchronous reset, active-low (0 = reset)
//  req_if     in   1   fetch read request, held until done_if
//  addr_if    in   AW  fetch address
//  req_d      in   1   data request, held until done_d
//  we_d       in   1   1 = write, 0 = read
//  addr_d     in   AW  data address
//  wdata_d    in   DW  data write value
//  gnt_if     out  1   high while IF transaction is in progress
//  gnt_d      out  1   high while D transaction is in progress
//  done_if    out  1   1-cycle pulse: IF transaction complete
//  done_d     out  1   1-cycle pulse: D transaction complete
//  rdata      out  DW  read data, valid in the done cycle and held until the next done
//  err        out  1   1-cycle pulse with done: transaction aborted
//  mem_req    out  1   memory command valid
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, valid with mem_ack
//  mem_ack    in   1   1-cycle memory completion
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE, last=D. All outputs are 0: gnt_*, done_*, err, mem_*, rdata.
//    Reset mid-transaction abandons the transaction. No done is issued for it.
//  - FSM, one-hot, 3 states: IDLE, BUSY_IF, BUSY_D.
//  - IDLE, only one request pending: go to the BUSY state for that request.
//  - IDLE, both requests pending: grant the requester that is not `last`. Round-robin.
//    After reset, IF wins the first tie.
//  - Entering BUSY_x: latch the address, we and wdata into the mem_* registers, set mem_req=1,
//    set gnt_x=1 and set last=x.
//  - Latency: a request sampled at edge N gives mem_req=1 after edge N.
//  - In BUSY_x, mem_ack=1 at edge M captures mem_rdata into rdata. The IF path always reads.
//    After edge M: done_x=1 for one cycle, mem_req=0, gnt_x=0, state=IDLE.
//  - The cycle after done is a turnaround cycle: no new grant is issued in the same edge.
//    Minimum spacing between mem_req assertions is 2 cycles.
//  - mem_* command outputs are stable while mem_req=1. The latched copies are used, so
//    requester inputs may change.
//  - A requester dropping req mid-transaction has no effect. The transaction still completes
//    and done still pulses.
//  - mem_ack while in IDLE is ignored.
//  - Write transactions leave rdata unchanged.
// CONFIGURATION
//  - Macro ARB_TIMEOUT_EN defined:
//    - A counter clears on entry to BUSY and increments each cycle while in BUSY.
//    - When the count reaches TIMEOUT with no ack: done_x=1, err=1, rdata=16'hFFFF,
//      mem_req=0, state=IDLE.
//    - mem_ack on the same edge as the timeout takes priority: normal completion, err=0.
//  - Macro undefined: no counter. BUSY waits for mem_ack indefinitely and err is tied to 0.
// STRUCTURE
//  - Package arb_pkg:
//    - localparams S_IDLE=3'b001, S_BUSY_IF=3'b010, S_BUSY_D=3'b100
//    - REQ_IF=1'b0, REQ_D=1'b1 (encoding of `last`)
//    - default AW and DW
//    - TIMEOUT_VAL=16'hFFFF
//  - One sub-module, arb_wdog: the timeout counter with clear, enable and expired outputs.
//    It is instantiated only under ARB_TIMEOUT_EN.
// TESTING
//  1. req_d=1, we_d=0, addr_d=16'h0040; ack 3 cycles after mem_req with mem_rdata=16'hBEEF.
//     Expect: mem_addr=0040, mem_we=0; done_d for 1 cycle; rdata=BEEF.
//  2. req_if and req_d both rise in the same cycle after reset, ack latency 1.
//     Expect: IF is served first, then D. done_if precedes done_d.
//     The two mem_req assertions are separated by exactly 1 idle cycle.
//  3. Write: we_d=1, addr=16'h0010, wdata=16'h1234; wdata_d is changed while BUSY.
//     Expect: mem_wdata stays at 1234 and rdata keeps its prior value.
//  4. rst=0 pulsed while in BUSY_D before ack, with mem_ack arriving afterwards.
//     Expect: all outputs 0, no done, the late ack is ignored and the next request proceeds normally.
//  5. ARB_TIMEOUT_EN with TIMEOUT=4 and no ack.
//     Expect: done and err pulse together 4 cycles after mem_req rises; rdata=FFFF; state=IDLE.
//     Without the macro, the same stimulus keeps gnt high.
//  6. Ack arrives on the same edge as the timeout expiry.
//     Expect: err=0 and rdata equals mem_rdata.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants for the memory port arbiter.
// Contents: one-hot FSM state encodings, the `last` requester encoding,
// default bus widths, the data value returned on an aborted transaction,
// and the round-robin pick helper.
package arb_pkg;
  localparam logic [2:0] S_IDLE    = 3'b001;
  localparam logic [2:0] S_BUSY_IF = 3'b010;
  localparam logic [2:0] S_BUSY_D  = 3'b100;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  localparam int ARB_AW = 16;
  localparam int ARB_DW = 16;

  localparam logic [15:0] TIMEOUT_VAL = 16'hFFFF;

  // Returns {take_d, take_if}. On a tie the requester that did not go last wins.
  function automatic logic [1:0] rr_pick(input logic pend_if, input logic pend_d,
                                         input logic last);
    if (pend_if && pend_d) return (last == REQ_IF) ? 2'b10 : 2'b01;
    return {pend_d, pend_if};
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (fetch IF, mem stage D), the arbiter
// and the single-port memory.
//   slave  : arbiter view (requests + memory response in, grants/done/mem cmd out)
//   master : requester/memory-model view (the reverse)
interface mem_port_arbiter_if #(
  parameter int AW = arb_pkg::ARB_AW,
  parameter int DW = arb_pkg::ARB_DW
);
  logic          req_if;
  logic [AW-1:0] addr_if;
  logic          req_d;
  logic          we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic          gnt_if;
  logic          gnt_d;
  logic          done_if;
  logic          done_d;
  logic [DW-1:0] rdata;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport slave (
    input  req_if, addr_if, req_d, we_d, addr_d, wdata_d, mem_rdata, mem_ack,
    output gnt_if, gnt_d, done_if, done_d, rdata, err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_if, addr_if, req_d, we_d, addr_d, wdata_d, mem_rdata, mem_ack,
    input  gnt_if, gnt_d, done_if, done_d, rdata, err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arb_wdog.sv
// Transaction watchdog for the memory port arbiter (only built with ARB_TIMEOUT_EN).
// Ports:
//   clk, rst   clock, synchronous active-low reset
//   i_clr      zero the count (asserted on the edge that starts a transaction)
//   i_en       count this cycle (transaction in progress)
//   o_expired  the edge about to be taken is the TIMEOUT-th cycle of the transaction
module arb_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst)       r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + CW'(1);
  end

  // Fires one edge early so the abort lands on the edge where the count reaches TIMEOUT.
  assign o_expired = i_en && (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch stage (IF, read only) and
// the mem stage (D, read/write). One transaction at a time; round-robin on ties.
// Ports:
//   clk, rst  single clock, synchronous active-low reset
//   bus       mem_port_arbiter_if.slave: requester handshakes, grants, done
//             pulses, rdata/err, registered memory command, memory response
// Optional: define ARB_TIMEOUT_EN to abort a transaction after TIMEOUT cycles
// without mem_ack (done + err, rdata = all ones). Without it err stays 0 and
// the arbiter waits for mem_ack indefinitely.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int AW      = ARB_AW,
  parameter int DW      = ARB_DW,
  parameter int TIMEOUT = 15
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);
  logic [2:0]    r_state;
  logic          r_last;
  logic          r_gnt_if, r_gnt_d, r_done_if, r_done_d, r_err;
  logic          r_mem_req, r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata, r_rdata;

  logic          w_pend_if, w_pend_d, w_start, w_expired;
  logic [1:0]    w_pick;

  // A requester still showing req while its done pulses has not seen done yet;
  // that req belongs to the finished transaction, so it must not re-grant.
  assign w_pend_if = bus.req_if & ~r_done_if;
  assign w_pend_d  = bus.req_d  & ~r_done_d;
  assign w_pick    = rr_pick(w_pend_if, w_pend_d, r_last);
  assign w_start   = (r_state == S_IDLE) && (w_pick != 2'b00);

`ifdef ARB_TIMEOUT_EN
  arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_start),
    .i_en      (r_state != S_IDLE),
    .o_expired (w_expired)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_expired        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_last      <= REQ_D;
      r_gnt_if    <= 1'b0;
      r_gnt_d     <= 1'b0;
      r_done_if   <= 1'b0;
      r_done_d    <= 1'b0;
      r_err       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_done_if <= 1'b0;
      r_done_d  <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Done cycle doubles as the turnaround: the state is already IDLE,
          // so a waiting requester is granted on the edge after done.
          if (w_pick[0]) begin
            r_state     <= S_BUSY_IF;
            r_gnt_if    <= 1'b1;
            r_last      <= REQ_IF;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= bus.addr_if;
            r_mem_wdata <= '0;
          end else if (w_pick[1]) begin
            r_state     <= S_BUSY_D;
            r_gnt_d     <= 1'b1;
            r_last      <= REQ_D;
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.we_d;
            r_mem_addr  <= bus.addr_d;
            r_mem_wdata <= bus.wdata_d;
          end
        end
        S_BUSY_IF, S_BUSY_D: begin
          if (bus.mem_ack || w_expired) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
            r_gnt_if  <= 1'b0;
            r_gnt_d   <= 1'b0;
            r_done_if <= (r_state == S_BUSY_IF);
            r_done_d  <= (r_state == S_BUSY_D);
            // ack wins over a coincident timeout
            if (bus.mem_ack) begin
              if (!r_mem_we) r_rdata <= bus.mem_rdata;
            end else begin
              r_err   <= 1'b1;
              r_rdata <= DW'(TIMEOUT_VAL);
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
          r_gnt_if  <= 1'b0;
          r_gnt_d   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_if    = r_gnt_if;
  assign bus.gnt_d     = r_gnt_d;
  assign bus.done_if   = r_done_if;
  assign bus.done_d    = r_done_d;
  assign bus.err       = r_err;
  assign bus.rdata     = r_rdata;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table applied one clock per
// row (inputs held across the edge, outputs compared on the following
// negedge), then hand-written timeout / ack-at-timeout sequences.
module tb_mem_port_arbiter;
  import arb_pkg::*;

  localparam logic        H = 1'b1;
  localparam logic        L = 1'b0;
  localparam logic [15:0] Z = 16'h0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(16), .DW(16)) bus();

  mem_port_arbiter #(.AW(16), .DW(16), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst, req_if;
    logic [15:0] addr_if;
    logic        req_d, we_d;
    logic [15:0] addr_d, wdata_d;
    logic        ack;
    logic [15:0] mrd;
    logic [54:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // {gnt_if, gnt_d, done_if, done_d, err, mem_req, mem_we, mem_addr, mem_wdata, rdata}
  function automatic logic [54:0] o(input logic gi, gd, di, dd, er, rq, we,
                                    input logic [15:0] a, wd, rd);
    return {gi, gd, di, dd, er, rq, we, a, wd, rd};
  endfunction

  function automatic logic [54:0] act();
    return {bus.gnt_if, bus.gnt_d, bus.done_if, bus.done_d, bus.err, bus.mem_req,
            bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rdata};
  endfunction

  function automatic string fmt(input logic [54:0] v);
    return $sformatf("gnt=%b%b done=%b%b err=%b req=%b we=%b addr=%h wd=%h rd=%h",
                     v[54], v[53], v[52], v[51], v[50], v[49], v[48],
                     v[47:32], v[31:16], v[15:0]);
  endfunction

  function automatic vec_t mk(input logic r, ri, input logic [15:0] ai,
                              input logic rd, we, input logic [15:0] ad, wd,
                              input logic ak, input logic [15:0] mrd,
                              input logic [54:0] e);
    vec_t v;
    v.rst = r; v.req_if = ri; v.addr_if = ai; v.req_d = rd; v.we_d = we;
    v.addr_d = ad; v.wdata_d = wd; v.ack = ak; v.mrd = mrd; v.exp = e;
    return v;
  endfunction

  task automatic set_in(input logic r, ri, input logic [15:0] ai,
                        input logic rd, we, input logic [15:0] ad, wd,
                        input logic ak, input logic [15:0] mrd);
    rst = r; bus.req_if = ri; bus.addr_if = ai; bus.req_d = rd; bus.we_d = we;
    bus.addr_d = ad; bus.wdata_d = wd; bus.mem_ack = ak; bus.mem_rdata = mrd;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [54:0] e);
    logic [54:0] a;
    a = act();
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got [%s] want [%s]", nm, fmt(a), fmt(e));
    end
  endtask

  logic [15:0] prev_rd;

  initial begin
    set_in(L, L, Z, L, L, Z, Z, L, Z);

    // reset
    tbl.push_back(mk(L,L,Z,L,L,Z,Z,L,Z,                         o(L,L,L,L,L,L,L,Z,Z,Z)));
    tbl.push_back(mk(L,L,Z,L,L,Z,Z,L,Z,                         o(L,L,L,L,L,L,L,Z,Z,Z)));
    // D read 0040, ack 3 cycles after mem_req
    tbl.push_back(mk(H,L,Z,H,L,16'h0040,Z,L,Z,                  o(L,H,L,L,L,H,L,16'h0040,Z,Z)));
    tbl.push_back(mk(H,L,Z,H,L,16'h0040,Z,L,Z,                  o(L,H,L,L,L,H,L,16'h0040,Z,Z)));
    tbl.push_back(mk(H,L,Z,H,L,16'h0040,Z,L,Z,                  o(L,H,L,L,L,H,L,16'h0040,Z,Z)));
    tbl.push_back(mk(H,L,Z,H,L,16'h0040,Z,H,16'hBEEF,           o(L,L,L,H,L,L,L,16'h0040,Z,16'hBEEF)));
    tbl.push_back(mk(H,L,Z,L,L,16'h0040,Z,L,Z,                  o(L,L,L,L,L,L,L,16'h0040,Z,16'hBEEF)));
    // reset, then simultaneous IF+D: IF first, one idle cycle, then D
    tbl.push_back(mk(L,L,Z,L,L,Z,Z,L,Z,                         o(L,L,L,L,L,L,L,Z,Z,Z)));
    tbl.push_back(mk(H,H,16'h0100,H,L,16'h0200,Z,L,Z,           o(H,L,L,L,L,H,L,16'h0100,Z,Z)));
    tbl.push_back(mk(H,H,16'h0100,H,L,16'h0200,Z,H,16'h1111,    o(L,L,H,L,L,L,L,16'h0100,Z,16'h1111)));
    tbl.push_back(mk(H,L,16'h0100,H,L,16'h0200,Z,L,Z,           o(L,H,L,L,L,H,L,16'h0200,Z,16'h1111)));
    tbl.push_back(mk(H,L,16'h0100,H,L,16'h0200,Z,H,16'h2222,    o(L,L,L,H,L,L,L,16'h0200,Z,16'h2222)));
    tbl.push_back(mk(H,L,Z,L,L,Z,Z,L,Z,                         o(L,L,L,L,L,L,L,16'h0200,Z,16'h2222)));
    // write 0010 <- 1234, requester inputs change while busy
    tbl.push_back(mk(H,L,Z,H,H,16'h0010,16'h1234,L,Z,           o(L,H,L,L,L,H,H,16'h0010,16'h1234,16'h2222)));
    tbl.push_back(mk(H,L,Z,H,H,16'h0FFF,16'h5678,L,Z,           o(L,H,L,L,L,H,H,16'h0010,16'h1234,16'h2222)));
    tbl.push_back(mk(H,L,Z,H,H,16'h0FFF,16'h5678,H,16'hDEAD,    o(L,L,L,H,L,L,H,16'h0010,16'h1234,16'h2222)));
    tbl.push_back(mk(H,L,Z,L,L,Z,Z,L,Z,                         o(L,L,L,L,L,L,H,16'h0010,16'h1234,16'h2222)));
    // IF alone, then tie with last=IF -> D, then IF again
    tbl.push_back(mk(H,H,16'h0300,L,L,Z,Z,L,Z,                  o(H,L,L,L,L,H,L,16'h0300,Z,16'h2222)));
    tbl.push_back(mk(H,H,16'h0300,H,L,16'h0400,Z,H,16'h3333,    o(L,L,H,L,L,L,L,16'h0300,Z,16'h3333)));
    tbl.push_back(mk(H,H,16'h0300,H,L,16'h0400,Z,L,Z,           o(L,H,L,L,L,H,L,16'h0400,Z,16'h3333)));
    tbl.push_back(mk(H,H,16'h0300,H,L,16'h0400,Z,H,16'h4444,    o(L,L,L,H,L,L,L,16'h0400,Z,16'h4444)));
    tbl.push_back(mk(H,H,16'h0300,L,L,Z,Z,L,Z,                  o(H,L,L,L,L,H,L,16'h0300,Z,16'h4444)));
    tbl.push_back(mk(H,H,16'h0300,L,L,Z,Z,H,16'h5555,           o(L,L,H,L,L,L,L,16'h0300,Z,16'h5555)));
    tbl.push_back(mk(H,L,Z,L,L,Z,Z,L,Z,                         o(L,L,L,L,L,L,L,16'h0300,Z,16'h5555)));
    // stray ack in IDLE ignored
    tbl.push_back(mk(H,L,Z,L,L,Z,Z,H,16'h9999,                  o(L,L,L,L,L,L,L,16'h0300,Z,16'h5555)));
    // reset during BUSY_D, late ack ignored, next request normal
    tbl.push_back(mk(H,L,Z,H,L,16'h0050,Z,L,Z,                  o(L,H,L,L,L,H,L,16'h0050,Z,16'h5555)));
    tbl.push_back(mk(L,L,Z,H,L,16'h0050,Z,L,Z,                  o(L,L,L,L,L,L,L,Z,Z,Z)));
    tbl.push_back(mk(H,L,Z,L,L,Z,Z,H,16'h7777,                  o(L,L,L,L,L,L,L,Z,Z,Z)));
    tbl.push_back(mk(H,L,Z,H,L,16'h0060,Z,L,Z,                  o(L,H,L,L,L,H,L,16'h0060,Z,Z)));
    tbl.push_back(mk(H,L,Z,H,L,16'h0060,Z,H,16'h6060,           o(L,L,L,H,L,L,L,16'h0060,Z,16'h6060)));
    tbl.push_back(mk(H,L,Z,L,L,Z,Z,L,Z,                         o(L,L,L,L,L,L,L,16'h0060,Z,16'h6060)));

    @(negedge clk);
    foreach (tbl[i]) begin
      set_in(tbl[i].rst, tbl[i].req_if, tbl[i].addr_if, tbl[i].req_d, tbl[i].we_d,
             tbl[i].addr_d, tbl[i].wdata_d, tbl[i].ack, tbl[i].mrd);
      cyc();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // no ack on a D read of 0070
    set_in(H, L, Z, H, L, 16'h0070, Z, L, Z);
    cyc();
    check("t5_grant", o(L,H,L,L,L,H,L,16'h0070,Z,16'h6060));
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check($sformatf("t5_wait%0d", k), o(L,H,L,L,L,H,L,16'h0070,Z,16'h6060));
    end
    cyc();
    check("t5_abort", o(L,L,L,H,H,L,L,16'h0070,Z,16'hFFFF));
    set_in(H, L, Z, L, L, Z, Z, L, Z);
    cyc();
    check("t5_idle", o(L,L,L,L,L,L,L,16'h0070,Z,16'hFFFF));
    prev_rd = 16'hFFFF;
`else
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check($sformatf("t5_hold%0d", k), o(L,H,L,L,L,H,L,16'h0070,Z,16'h6060));
    end
    set_in(H, L, Z, H, L, 16'h0070, Z, H, 16'hABCD);
    cyc();
    check("t5_late_ack", o(L,L,L,H,L,L,L,16'h0070,Z,16'hABCD));
    set_in(H, L, Z, L, L, Z, Z, L, Z);
    cyc();
    check("t5_idle", o(L,L,L,L,L,L,L,16'h0070,Z,16'hABCD));
    prev_rd = 16'hABCD;
`endif

    // ack lands on the timeout edge: normal completion
    set_in(H, L, Z, H, L, 16'h0080, Z, L, Z);
    cyc();
    check("t6_grant", o(L,H,L,L,L,H,L,16'h0080,Z,prev_rd));
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check($sformatf("t6_wait%0d", k), o(L,H,L,L,L,H,L,16'h0080,Z,prev_rd));
    end
    set_in(H, L, Z, H, L, 16'h0080, Z, H, 16'hC0DE);
    cyc();
    check("t6_ack_wins", o(L,L,L,H,L,L,L,16'h0080,Z,16'hC0DE));
    set_in(H, L, Z, L, L, Z, Z, L, Z);
    cyc();
    check("t6_idle", o(L,L,L,L,L,L,L,16'h0080,Z,16'hC0DE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
